// File: rtl/mesh_term_sink.sv
// mesh_term_sink: drains one mesh output port into a local FIFO read by the host.
// Define MESH_TERM_SINK_CHECK_EN to drop misrouted packets and count them in err_cnt.
module mesh_term_sink #(
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 4,
    parameter logic [3:0] MY_ROW     = 4'd0,
    parameter logic [3:0] MY_COL     = 4'd0,
    parameter logic [7:0] bdcst      = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng,
    input  logic [pckg_sz-1:0] data_out,
    output logic               pop,
    output logic [pckg_sz-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        rx_cnt,
    output logic [15:0]        err_cnt,
    output logic               full
);

    localparam int AW = $clog2(fifo_depth);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    state_t             state, next_state;
    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [pckg_sz-1:0] stage_data;
    logic               stage_valid;
    logic               host_read;
    logic               push;
    logic               match;

`ifdef MESH_TERM_SINK_CHECK_EN
    logic [7:0] dest;
    assign dest  = data_out[pckg_sz-9:pckg_sz-16];
    assign match = (dest == {MY_ROW, MY_COL}) || (dest == bdcst);
`else
    logic unused_cfg;
    assign unused_cfg = ^{MY_ROW, MY_COL, bdcst};
    assign match      = 1'b1;
`endif

    assign out_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign host_read = out_ready && out_valid;
    assign push      = (state == SETTLE) && stage_valid;

    // A concurrent host read frees a slot, so a full FIFO may still start a pop.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pndng && (!full || host_read)) next_state = POP;
            POP:     next_state = SETTLE;
            SETTLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pop   <= 1'b0;
        end else begin
            state <= next_state;
            pop   <= (next_state == POP);
        end
    end

    // The word is staged at the end of POP and written at the end of SETTLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_data  <= '0;
            stage_valid <= 1'b0;
            rx_cnt      <= 16'd0;
        end else if (state == POP) begin
            stage_data  <= data_out;
            stage_valid <= match;
            if (match && rx_cnt != 16'hFFFF) rx_cnt <= rx_cnt + 16'd1;
        end else if (state == SETTLE) begin
            stage_valid <= 1'b0;
        end
    end

`ifdef MESH_TERM_SINK_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= 16'd0;
        end else if (state == POP && !match && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_cnt = 16'd0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)      wr_ptr <= wr_ptr + (AW+1)'(1);
            if (host_read) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= stage_data;
    end

endmodule

// File: tb/tb_mesh_term_sink.sv
// Self-checking bench for mesh_term_sink on terminal (2,1) with a 4-entry FIFO.
// A queue models the mesh output FIFO; a scoreboard holds the words the host should read.
module tb_mesh_term_sink;

    logic        clk;
    logic        reset;
    logic        pndng;
    logic [39:0] data_out;
    logic        pop;
    logic [39:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] rx_cnt;
    logic [15:0] err_cnt;
    logic        full;

    int errors = 0;
    int checks = 0;

    logic [39:0] mesh_q[$];
    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];
    int          exp_rx, exp_err, pop_count, bad_pops, cyc;

    mesh_term_sink #(
        .pckg_sz(40), .fifo_depth(4), .MY_ROW(4'd2), .MY_COL(4'd1), .bdcst(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .rx_cnt(rx_cnt), .err_cnt(err_cnt), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] mk(logic [3:0] row, logic [3:0] col, logic [22:0] payload);
        return {8'h00, row, col, 1'b0, payload};
    endfunction

    function automatic bit accepts(logic [39:0] w);
`ifdef MESH_TERM_SINK_CHECK_EN
        return (w[31:24] == 8'h21) || (w[31:24] == 8'hFF);
`else
        return 1'b1;
`endif
    endfunction

    task automatic refresh();
        pndng    = (mesh_q.size() != 0);
        data_out = (mesh_q.size() != 0) ? mesh_q[0] : 40'd0;
    endtask

    task automatic mesh_put(logic [39:0] w);
        mesh_q.push_back(w);
        refresh();
    endtask

    // One clock: the mesh honours a pop seen at the edge, the host takes a word on a read.
    task automatic tick();
        logic        popw, rdw;
        logic [39:0] rdd, w;
        popw = pop;
        rdw  = out_valid && out_ready;
        rdd  = out_data;
        @(posedge clk);
        #1;
        if (popw) begin
            if (mesh_q.size() == 0) begin
                bad_pops++;
            end else begin
                w = mesh_q.pop_front();
                pop_count++;
                if (accepts(w)) begin
                    exp_q.push_back(w);
                    exp_rx++;
                end else begin
                    exp_err++;
                end
            end
        end
        if (rdw) obs_q.push_back(rdd);
        refresh();
        cyc++;
    endtask

    task automatic clear_model();
        mesh_q.delete();
        exp_q.delete();
        obs_q.delete();
        exp_rx = 0; exp_err = 0; pop_count = 0;
        refresh();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        out_ready = 1'b0;
        clear_model();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [39:0] w;
        reset     = 1'b0;
        out_ready = 1'b0;
        clear_model();
        w = mk(4'd2, 4'd1, 23'h11);
        mesh_put(w);
        repeat (3) tick();
        checks++; if (pop !== 1'b0)       begin errors++; $display("[TB] FAIL reset_pop got=%b exp=0", pop); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 40'd0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (full !== 1'b0)      begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
        checks++; if (rx_cnt !== 16'd0)   begin errors++; $display("[TB] FAIL reset_rx got=%0d exp=0", rx_cnt); end
        checks++; if (err_cnt !== 16'd0)  begin errors++; $display("[TB] FAIL reset_err got=%0d exp=0", err_cnt); end
        reset = 1'b1;
        tick();
        checks++; if (pop !== 1'b1) begin errors++; $display("[TB] FAIL first_pop got=%b exp=1", pop); end
        tick();
        checks++; if (pop !== 1'b0) begin errors++; $display("[TB] FAIL pop_width got=%b exp=0", pop); end
        checks++; if (rx_cnt !== 16'(exp_rx)) begin errors++; $display("[TB] FAIL rx_after_pop got=%0d exp=%0d", rx_cnt, exp_rx); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL early_valid got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL valid_latency got=%b exp=1", out_valid); end
        checks++; if (out_data !== w) begin errors++; $display("[TB] FAIL head_data got=%h exp=%h", out_data, w); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drained_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int rises[$];
        do_reset();
        out_ready = 1'b1;
        mesh_put(mk(4'd2, 4'd1, 23'h11));
        mesh_put(mk(4'd2, 4'd1, 23'h22));
        mesh_put(mk(4'd2, 4'd1, 23'h33));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pop) rises.push_back(cyc);
        end
        checks++; if (rises.size() != 3) begin errors++; $display("[TB] FAIL b2b_pops got=%0d exp=3", rises.size()); end
        for (int i = 1; i < rises.size(); i++) begin
            checks++;
            if (rises[i] - rises[i-1] != 3) begin
                errors++; $display("[TB] FAIL b2b_spacing got=%0d exp=3", rises[i] - rises[i-1]);
            end
        end
        checks++; if (rx_cnt !== 16'd3) begin errors++; $display("[TB] FAIL b2b_rx got=%0d exp=3", rx_cnt); end
        checks++; if (obs_q.size() != 3) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            checks++;
            if (obs_q[i][22:0] !== 23'(8'h11 * (i + 1))) begin
                errors++; $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", i, obs_q[i][22:0], 8'h11 * (i + 1));
            end
        end
    endtask

    task automatic test_dest(logic [7:0] rc, string name);
        bit seen_valid = 0;
        do_reset();
        out_ready = 1'b1;
        mesh_put(mk(rc[7:4], rc[3:0], 23'($urandom)));
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen_valid = 1;
        end
        checks++; if (rx_cnt !== 16'(exp_rx)) begin errors++; $display("[TB] FAIL %s_rx got=%0d exp=%0d", name, rx_cnt, exp_rx); end
        checks++; if (err_cnt !== 16'(exp_err)) begin errors++; $display("[TB] FAIL %s_err got=%0d exp=%0d", name, err_cnt, exp_err); end
        checks++; if (seen_valid != (exp_q.size() != 0)) begin errors++; $display("[TB] FAIL %s_valid got=%0d exp=%0d", name, seen_valid, exp_q.size()); end
        checks++; if (obs_q != exp_q) begin errors++; $display("[TB] FAIL %s_data got=%0d words exp=%0d words", name, obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 6; i++) mesh_put(mk(4'd2, 4'd1, 23'($urandom)));
        repeat (30) tick();
        checks++; if (pop_count != 4) begin errors++; $display("[TB] FAIL full_pops got=%0d exp=4", pop_count); end
        checks++; if (full !== 1'b1)  begin errors++; $display("[TB] FAIL full_flag got=%b exp=1", full); end
        checks++; if (pop !== 1'b0)   begin errors++; $display("[TB] FAIL full_pop got=%b exp=0", pop); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (10) tick();
        checks++; if (pop_count != 5) begin errors++; $display("[TB] FAIL full_one_more got=%0d exp=5", pop_count); end
        checks++; if (full !== 1'b1)  begin errors++; $display("[TB] FAIL full_refill got=%b exp=1", full); end
        out_ready = 1'b1;
        repeat (30) tick();
        checks++; if (obs_q != exp_q || obs_q.size() != 6) begin
            errors++; $display("[TB] FAIL full_nolose got=%0d words exp=6 in order", obs_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] rc;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       rc = 8'h21;
                1:       rc = 8'hFF;
                default: rc = 8'($urandom);
            endcase
            mesh_put(mk(rc[7:4], rc[3:0], 23'($urandom)));
        end
        for (int i = 0; i < 150; i++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        out_ready = 1'b1;
        repeat (80) tick();
        checks++; if (mesh_q.size() != 0) begin errors++; $display("[TB] FAIL rand_timeout got=%0d left exp=0", mesh_q.size()); end
        checks++; if (rx_cnt !== 16'(exp_rx)) begin errors++; $display("[TB] FAIL rand_rx got=%0d exp=%0d", rx_cnt, exp_rx); end
        checks++; if (err_cnt !== 16'(exp_err)) begin errors++; $display("[TB] FAIL rand_err got=%0d exp=%0d", err_cnt, exp_err); end
        checks++; if (obs_q != exp_q) begin errors++; $display("[TB] FAIL rand_data got=%0d words exp=%0d words", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_during_pop();
        logic [39:0] w;
        int          n = 0;
        do_reset();
        w = mk(4'd2, 4'd1, 23'h5A5A5);
        mesh_put(w);
        while (pop !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++; if (pop !== 1'b1) begin errors++; $display("[TB] FAIL rdp_timeout got=%b exp=1", pop); end
        #2 reset = 1'b0;
        #1;
        exp_rx = 0; exp_err = 0;
        checks++; if (pop !== 1'b0)       begin errors++; $display("[TB] FAIL rdp_pop_async got=%b exp=0", pop); end
        checks++; if (rx_cnt !== 16'd0)   begin errors++; $display("[TB] FAIL rdp_rx got=%0d exp=0", rx_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdp_valid got=%b exp=0", out_valid); end
        tick();
        checks++; if (mesh_q.size() != 1) begin errors++; $display("[TB] FAIL rdp_pending got=%0d exp=1", mesh_q.size()); end
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (8) tick();
        checks++; if (rx_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rdp_restart_rx got=%0d exp=1", rx_cnt); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== w) begin
            errors++; $display("[TB] FAIL rdp_restart_data got=%0d words exp=1 word %h", obs_q.size(), w);
        end
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b0;
        pndng     = 1'b0;
        data_out  = 40'd0;
        bad_pops  = 0;
        cyc       = 0;
        test_reset();
        test_back_to_back();
        test_dest(8'h34, "misroute");
        test_dest(8'hFF, "bcast");
        test_dest(8'h21, "own");
        test_full();
        test_random();
        test_reset_during_pop();
        checks++; if (bad_pops != 0) begin errors++; $display("[TB] FAIL pop_when_empty got=%0d exp=0", bad_pops); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
